// File: rtl/cr_prefix_be_ctlr.sv
// cr_prefix_be_ctlr: reads committed prefix buffer banks round-robin and streams them out as 64-bit words.
// Define CR_PREFIX_BE_STATS_EN to add the be_stat_blks / be_stat_bytes counters.
module cr_prefix_be_ctlr #(
  parameter int NUM_BANKS = 4,
  parameter int BLK_WORDS = 128,
  parameter int RD_LAT    = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          fe_blk_wr,
  input  logic [$clog2(NUM_BANKS)-1:0]                  fe_blk_sel,
  input  logic [$clog2(BLK_WORDS):0]                    fe_blk_nwords,
  input  logic [3:0]                                    fe_blk_lvbytes,
  input  logic                                          fe_blk_eot,
  output logic                                          be_rd_en,
  output logic [$clog2(NUM_BANKS)+$clog2(BLK_WORDS)-1:0] be_rd_addr,
  input  logic [63:0]                                   be_rd_data,
  output logic [63:0]                                   be_data,
  output logic [3:0]                                    be_vbytes,
  output logic                                          be_eot,
  output logic                                          be_valid,
  input  logic                                          be_ready,
  output logic [NUM_BANKS-1:0]                          be_bank_free,
`ifdef CR_PREFIX_BE_STATS_EN
  output logic [15:0]                                   be_stat_blks,
  output logic [31:0]                                   be_stat_bytes,
`endif
  output logic                                          be_ovfl_err
);
  localparam int BW    = $clog2(NUM_BANKS);
  localparam int WW    = $clog2(BLK_WORDS);
  localparam int DEPTH = 2 + RD_LAT;
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD_BLK, S_DRAIN, S_RELEASE} state_t;

  state_t               r_state, w_next;
  logic [NUM_BANKS-1:0] r_full;
  logic [WW:0]          r_nwords [NUM_BANKS];
  logic [3:0]           r_lvb    [NUM_BANKS];
  logic                 r_eot    [NUM_BANKS];
  logic [BW-1:0]        r_ptr;
  logic [WW-1:0]        r_word;
  logic                 r_ovfl;
  logic [RD_LAT-1:0]    r_pend, r_plast;
  logic [63:0]          r_fd [DEPTH];
  logic [3:0]           r_fv [DEPTH];
  logic                 r_fe [DEPTH];
  logic [PW-1:0]        r_wp, r_rp;
  logic [PW:0]          r_cnt;

  logic                 w_release, w_commit, w_ovfl, w_credit, w_rd, w_last_rd;
  logic                 w_push, w_pop, w_drained;
  logic [WW:0]          w_nw;
  logic [PW:0]          w_outs;
  logic [NUM_BANKS-1:0] w_free, w_set;

  assign w_release = (r_state == S_RELEASE);
  // a bank being released this cycle may be re-committed at once; the commit wins
  assign w_commit  = fe_blk_wr & (~r_full[fe_blk_sel] | (w_release & (r_ptr == fe_blk_sel)));
  assign w_ovfl    = fe_blk_wr & ~w_commit;
  assign w_nw      = (fe_blk_nwords == '0) ? (WW+1)'(1) :
                     (fe_blk_nwords > (WW+1)'(BLK_WORDS)) ? (WW+1)'(BLK_WORDS) : fe_blk_nwords;
  assign w_free    = w_release ? NUM_BANKS'(1) << r_ptr : '0;
  assign w_set     = w_commit ? NUM_BANKS'(1) << fe_blk_sel : '0;

  always_comb begin
    w_outs = '0;
    for (int i = 0; i < RD_LAT; i++) w_outs = w_outs + (PW+1)'(r_pend[i]);
  end

  // reads in flight plus buffered words never exceed the FIFO depth
  assign w_credit  = (w_outs + r_cnt) < (PW+1)'(DEPTH);
  assign w_rd      = (r_state == S_RD_BLK) & w_credit;
  assign w_last_rd = ({1'b0, r_word} == r_nwords[r_ptr] - (WW+1)'(1));
  assign w_push    = r_pend[RD_LAT-1];
  assign w_pop     = be_valid & be_ready;
  assign w_drained = (w_outs == '0) & ((r_cnt == '0) | ((r_cnt == (PW+1)'(1)) & w_pop));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_full[r_ptr]) w_next = S_RD_BLK;
      S_RD_BLK: if (w_rd & w_last_rd) w_next = S_DRAIN;
      S_DRAIN:  if (w_drained) w_next = S_RELEASE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_full  <= '0;
      r_ptr   <= '0;
      r_word  <= '0;
      r_ovfl  <= 1'b0;
      r_pend  <= '0;
      r_plast <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state    <= w_next;
      r_full     <= (r_full & ~w_free) | w_set;
      r_ptr      <= w_release ? r_ptr + 1'b1 : r_ptr;
      r_word     <= (r_state == S_RD_BLK) ? (w_rd ? r_word + 1'b1 : r_word) : '0;
      r_ovfl     <= w_ovfl;
      r_pend[0]  <= w_rd;
      r_plast[0] <= w_rd & w_last_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pend[i]  <= r_pend[i-1];
        r_plast[i] <= r_plast[i-1];
      end
      if (w_push) r_wp <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_nwords[fe_blk_sel] <= w_nw;
      r_lvb[fe_blk_sel]    <= fe_blk_lvbytes;
      r_eot[fe_blk_sel]    <= fe_blk_eot;
    end
    if (w_push) begin
      r_fd[r_wp] <= be_rd_data;
      r_fv[r_wp] <= r_plast[RD_LAT-1] ? r_lvb[r_ptr] : 4'd8;
      r_fe[r_wp] <= r_plast[RD_LAT-1] & r_eot[r_ptr];
    end
  end

  assign be_rd_en     = w_rd;
  assign be_rd_addr   = {r_ptr, r_word};
  assign be_valid     = (r_cnt != '0);
  assign be_data      = be_valid ? r_fd[r_rp] : '0;
  assign be_vbytes    = be_valid ? r_fv[r_rp] : '0;
  assign be_eot       = be_valid & r_fe[r_rp];
  assign be_bank_free = w_free;
  assign be_ovfl_err  = r_ovfl;

`ifdef CR_PREFIX_BE_STATS_EN
  logic [15:0] r_blks;
  logic [31:0] r_bytes;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blks  <= '0;
      r_bytes <= '0;
    end else begin
      r_blks  <= r_blks + 16'(w_release);
      r_bytes <= r_bytes + (w_pop ? 32'(be_vbytes) : 32'd0);
    end
  end
  assign be_stat_blks  = r_blks;
  assign be_stat_bytes = r_bytes;
`endif
endmodule

// File: tb/tb_cr_prefix_be_ctlr.sv
// tb_cr_prefix_be_ctlr: scoreboard bench for cr_prefix_be_ctlr with a bank-level reference model and SRAM model.
module tb_cr_prefix_be_ctlr;
  logic        clk = 0, rst_n = 0;
  logic        fe_blk_wr = 0, fe_blk_eot = 0, be_ready = 1;
  logic [1:0]  fe_blk_sel = 0;
  logic [7:0]  fe_blk_nwords = 0;
  logic [3:0]  fe_blk_lvbytes = 0;
  logic        be_rd_en, be_eot, be_valid, be_ovfl_err;
  logic [8:0]  be_rd_addr;
  logic [63:0] be_rd_data = 0, be_data;
  logic [3:0]  be_vbytes, be_bank_free;

  always #5 clk = ~clk;

  cr_prefix_be_ctlr dut (
    .clk(clk), .rst_n(rst_n), .fe_blk_wr(fe_blk_wr), .fe_blk_sel(fe_blk_sel),
    .fe_blk_nwords(fe_blk_nwords), .fe_blk_lvbytes(fe_blk_lvbytes), .fe_blk_eot(fe_blk_eot),
    .be_rd_en(be_rd_en), .be_rd_addr(be_rd_addr), .be_rd_data(be_rd_data), .be_data(be_data),
    .be_vbytes(be_vbytes), .be_eot(be_eot), .be_valid(be_valid), .be_ready(be_ready),
    .be_bank_free(be_bank_free), .be_ovfl_err(be_ovfl_err)
  );

  logic [63:0] mem [512];
  always @(posedge clk) if (be_rd_en) be_rd_data <= mem[be_rd_addr];

  typedef struct {logic [63:0] d; logic [3:0] vb; logic eot;} word_t;
  word_t       exp_q[$];
  logic [8:0]  addr_q[$];
  int          free_q[$];
  bit          m_full[4], m_queued[4], m_eot[4];
  int          m_nw[4], m_lv[4];
  int          m_ptr = 0, ovfl_exp = 0, ovfl_seen = 0;
  int          total = 0, bad = 0;
  bit          rnd_ready = 0, fixed_ready = 1;
  bit          stall_prev = 0;
  logic [63:0] hold_d;
  logic [3:0]  hold_vb;
  logic        hold_eot;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // queue the words of every committed bank in service order, starting from the model's read pointer
  function automatic void flush();
    word_t e;
    int idx;
    while (m_full[m_ptr] && !m_queued[m_ptr]) begin
      for (int w = 0; w < m_nw[m_ptr]; w++) begin
        idx   = m_ptr * 128 + w;
        e.d   = mem[idx];
        e.vb  = (w == m_nw[m_ptr] - 1) ? 4'(m_lv[m_ptr]) : 4'd8;
        e.eot = (w == m_nw[m_ptr] - 1) && m_eot[m_ptr];
        exp_q.push_back(e);
        addr_q.push_back(9'(idx));
      end
      free_q.push_back(m_ptr);
      m_queued[m_ptr] = 1;
      m_ptr = (m_ptr + 1) % 4;
    end
  endfunction

  task automatic commit(input int b, input int n, input int lv, input bit eot);
    if (!m_full[b]) for (int w = 0; w < 128; w++) mem[b*128+w] = {$urandom(), $urandom()};
    fe_blk_wr = 1; fe_blk_sel = 2'(b); fe_blk_nwords = 8'(n);
    fe_blk_lvbytes = 4'(lv); fe_blk_eot = eot;
    if (m_full[b]) ovfl_exp++;
    else begin
      m_full[b] = 1;
      m_nw[b]   = (n == 0) ? 1 : (n > 128) ? 128 : n;
      m_lv[b]   = lv;
      m_eot[b]  = eot;
      flush();
    end
    @(posedge clk); #1;
    fe_blk_wr = 0;
  endtask

  task automatic check_zero();
    check("rst_rd_en", be_rd_en, 0);
    check("rst_rd_addr", be_rd_addr, 0);
    check("rst_valid", be_valid, 0);
    check("rst_data", be_data, 0);
    check("rst_vbytes", be_vbytes, 0);
    check("rst_eot", be_eot, 0);
    check("rst_free", be_bank_free, 0);
    check("rst_ovfl", be_ovfl_err, 0);
  endtask

  task automatic reset_dut();
    rst_n = 0;
    exp_q.delete(); addr_q.delete(); free_q.delete();
    for (int b = 0; b < 4; b++) begin m_full[b] = 0; m_queued[b] = 0; end
    m_ptr = 0;
    @(negedge clk);
    check_zero();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || free_q.size() != 0) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_timeout", exp_q.size() + free_q.size(), 0);
  endtask

  task automatic wait_free(input int b);
    int c = 0;
    while (m_full[b] && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    check("bank_wait_timeout", m_full[b], 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    be_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (be_rd_en) begin
        if (addr_q.size() == 0) check("rd_unexpected", be_rd_en, 0);
        else check("rd_addr", be_rd_addr, addr_q.pop_front());
      end
      if (stall_prev) begin
        check("hold_valid", be_valid, 1);
        check("hold_data", be_data, hold_d);
        check("hold_vbytes", be_vbytes, hold_vb);
        check("hold_eot", be_eot, hold_eot);
      end
      if (be_valid && be_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", be_valid, 0);
        else begin
          word_t e;
          e = exp_q.pop_front();
          check("out_data", be_data, e.d);
          check("out_vbytes", be_vbytes, e.vb);
          check("out_eot", be_eot, e.eot);
        end
      end
      if (be_bank_free != 0) begin
        if (free_q.size() == 0) check("free_unexpected", be_bank_free, 0);
        else begin
          int b;
          b = free_q.pop_front();
          check("bank_free", be_bank_free, 64'(1) << b);
          m_full[b]   = 0;
          m_queued[b] = 0;
        end
      end
      if (be_ovfl_err) ovfl_seen++;
      stall_prev = be_valid && !be_ready;
      hold_d = be_data; hold_vb = be_vbytes; hold_eot = be_eot;
    end else stall_prev = 0;
  end

  initial begin
    int hs, rc, n;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    reset_dut();
    // full bank, latency and streaming rate
    commit(0, 128, 8, 0);
    @(negedge clk); check("lat_rd_c1", be_rd_en, 0);
    @(negedge clk); check("lat_rd_c2", be_rd_en, 1);
    @(negedge clk); check("lat_valid_c3", be_valid, 0);
    @(negedge clk); check("lat_valid_c4", be_valid, 1);
    hs = 0;
    repeat (127) begin @(negedge clk); hs += int'(be_valid && be_ready); end
    check("throughput", hs, 127);
    wait_done(500);
    // short bank with partial last word and end of frame
    reset_dut();
    commit(0, 3, 5, 1);
    wait_done(200);
    // bank1 waits for bank0
    reset_dut();
    commit(1, 7, 3, 1);
    rc = 0;
    repeat (20) begin @(negedge clk); rc += int'(be_rd_en); end
    check("no_read_out_of_order", rc, 0);
    @(posedge clk); #1;
    commit(0, 4, 8, 0);
    wait_done(300);
    // overflow on a full bank
    reset_dut();
    commit(2, 5, 6, 0);
    commit(2, 9, 2, 1);
    commit(0, 2, 8, 0);
    commit(1, 1, 1, 1);
    wait_done(300);
    // random traffic with backpressure, all banks, saturating word counts
    reset_dut();
    rnd_ready = 1;
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 4; b++) begin
        wait_free(b);
        n = $urandom_range(0, 9);
        n = (n == 0) ? 0 : (n == 1) ? 200 : (n == 2) ? 128 : $urandom_range(1, 40);
        commit(b, n, $urandom_range(1, 8), 1'($urandom_range(0, 1)));
      end
    wait_done(20000);
    // reset in the middle of a stalled bank
    rnd_ready = 0; fixed_ready = 0;
    @(posedge clk); #1;
    commit(0, 10, 4, 1);
    repeat (8) @(posedge clk);
    #1;
    reset_dut();
    fixed_ready = 1;
    commit(0, 6, 7, 0);
    wait_done(300);
    check("ovfl_count", ovfl_seen, ovfl_exp);
    check("addr_q_left", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
